// File: rtl/bitslip_align.sv
// Word aligner between the deserializer and the slip detector: barrel-shifts the
// raw word stream on slip requests and qualifies lock on a repeated training word.
module bitslip_align #(
  parameter int               WIDTH         = 10,
  parameter logic [WIDTH-1:0] PATTERN       = 'h01F,
  parameter int               SETTLE_CYCLES = 4,
  parameter int               LOCK_COUNT    = 8,
  parameter int               LOSS_COUNT    = 4,
  parameter int               ERR_SLIPS     = 20
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             slip_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [3:0]       shift,
  output logic             locked,
  output logic             lock_lost,
  output logic             align_err
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(ERR_SLIPS + 1);
  localparam int IW = $clog2(2 * WIDTH);

  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LAST    = BW'(LOSS_COUNT - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SLIP_MAX    = CW'(ERR_SLIPS);
  localparam logic [CW-1:0] SLIP_PRE    = CW'(ERR_SLIPS - 1);
  localparam logic [3:0]    SHIFT_LAST  = 4'(WIDTH - 1);

  typedef enum logic [1:0] {
    HUNT,
    SETTLE,
    LOCKED
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   r0, r1;
  logic [2*WIDTH-1:0] cat;
  logic [IW-1:0]      sel;
  logic               match;

  logic [GW-1:0] good_cnt, good_nxt;
  logic [BW-1:0] bad_cnt, bad_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [CW-1:0] slip_cnt, slip_nxt;
  logic [3:0]    shift_nxt;
  logic          lock_lost_nxt;
  logic          align_err_nxt;
  logic          slip_take;

  // r0 holds the newer word, so any window of WIDTH bits spans the word boundary.
  assign cat = {r0, r1};
  assign sel = IW'(shift);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r0   <= '0;
      r1   <= '0;
      dout <= '0;
    end else begin
      r0   <= din;
      r1   <= r0;
      dout <= cat[sel +: WIDTH];
    end
  end

  assign match      = (dout == PATTERN);
  assign dout_valid = locked;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= HUNT;
      shift      <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      settle_cnt <= '0;
      slip_cnt   <= '0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      good_cnt   <= good_nxt;
      bad_cnt    <= bad_nxt;
      settle_cnt <= settle_nxt;
      slip_cnt   <= slip_nxt;
      locked     <= (state_nxt == LOCKED);
      lock_lost  <= lock_lost_nxt;
      align_err  <= align_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift;
    good_nxt      = good_cnt;
    bad_nxt       = bad_cnt;
    settle_nxt    = settle_cnt;
    slip_nxt      = slip_cnt;
    lock_lost_nxt = 1'b0;
    slip_take     = 1'b0;

    case (state)
      HUNT: begin
        if (slip_in) begin
          slip_take = 1'b1;
        end else if (match) begin
          if (good_cnt == GOOD_LAST) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
            bad_nxt   = '0;
            slip_nxt  = '0;
          end else begin
            good_nxt = good_cnt + 1'b1;
          end
        end else begin
          good_nxt = '0;
        end
      end

      // Slip requests arriving while the shifted data flushes are dropped.
      SETTLE: begin
        good_nxt = '0;
        if (settle_cnt == '0) begin
          state_nxt = HUNT;
        end else begin
          settle_nxt = settle_cnt - 1'b1;
        end
      end

      LOCKED: begin
        if (slip_in) begin
          slip_take     = 1'b1;
          lock_lost_nxt = 1'b1;
        end else if (match) begin
          bad_nxt = '0;
        end else if (bad_cnt == BAD_LAST) begin
          state_nxt     = HUNT;
          lock_lost_nxt = 1'b1;
          bad_nxt       = '0;
          good_nxt      = '0;
        end else begin
          bad_nxt = bad_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase

    if (slip_take) begin
      shift_nxt  = (shift == SHIFT_LAST) ? 4'd0 : shift + 4'd1;
      settle_nxt = SETTLE_INIT;
      good_nxt   = '0;
      bad_nxt    = '0;
      state_nxt  = SETTLE;
      if (slip_cnt != SLIP_MAX) begin
        slip_nxt = slip_cnt + 1'b1;
      end
    end

    // The error is raised on the slip that reaches the limit; that beats a clear.
    align_err_nxt = align_err;
    if (clear_err) begin
      align_err_nxt = 1'b0;
    end
    if (slip_take && (slip_cnt == SLIP_PRE)) begin
      align_err_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_bitslip_align.sv
// Self-checking bench for bitslip_align: scoreboarded datapath plus lock, loss,
// slip wrap/settle and sticky error scenarios.
module tb_bitslip_align;

  localparam logic [9:0] PAT = 10'h01F;
  localparam logic [9:0] OFF = 10'h0F8;
  localparam logic [9:0] BAD = 10'h155;

  logic       clk = 1'b0;
  logic       resetn;
  logic [9:0] din;
  logic       slip_in;
  logic       clear_err;
  logic [9:0] dout;
  logic       dout_valid;
  logic [3:0] shift;
  logic       locked;
  logic       lock_lost;
  logic       align_err;

  int         checks = 0;
  int         failures = 0;
  int         exp_shift;
  int         ll_count = 0;
  int         ll_prev;
  logic [9:0] last_word;
  logic [9:0] sb_q[$];

  bitslip_align dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .slip_in    (slip_in),
    .clear_err  (clear_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .shift      (shift),
    .locked     (locked),
    .lock_lost  (lock_lost),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected dout one edge ahead is the window of the two newest words at the model shift.
  task automatic applyStimulus(input logic [9:0] word, input logic slip, input logic slip_ok,
                               input logic clr);
    logic [19:0] wcat;
    logic [9:0]  expv;
    din       = word;
    slip_in   = slip;
    clear_err = clr;
    if (slip && slip_ok) exp_shift = (exp_shift == 9) ? 0 : exp_shift + 1;
    wcat = {word, last_word};
    sb_q.push_back(wcat[exp_shift +: 10]);
    last_word = word;
    @(posedge clk);
    #1;
    slip_in   = 1'b0;
    clear_err = 1'b0;
    if (lock_lost) ll_count++;
    if (sb_q.size() > 1) begin
      expv = sb_q.pop_front();
      checkOutput("dout_sb", dout, expv);
    end
  endtask

  task automatic doReset();
    resetn    = 1'b0;
    din       = '0;
    slip_in   = 1'b0;
    clear_err = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_valid", dout_valid, 0);
    checkOutput("rst_shift", shift, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_lock_lost", lock_lost, 0);
    checkOutput("rst_align_err", align_err, 0);
    resetn    = 1'b1;
    last_word = '0;
    exp_shift = 0;
    sb_q.push_back(10'h000);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0] rw;
    doReset();

    // Aligned training stream locks on the 11th edge after release.
    for (int i = 1; i <= 11; i++) begin
      applyStimulus(PAT, 1'b0, 1'b0, 1'b0);
      if (i == 10) checkOutput("lock_early", locked, 0);
    end
    checkOutput("lock_at_11", locked, 1);
    checkOutput("valid_at_11", dout_valid, 1);
    checkOutput("aligned_dout", dout, PAT);

    // Three bad words are tolerated.
    ll_prev = ll_count;
    for (int i = 0; i < 12; i++) applyStimulus((i < 3) ? BAD : PAT, 1'b0, 1'b0, 1'b0);
    checkOutput("loss3_locked", locked, 1);
    checkOutput("loss3_no_pulse", ll_count - ll_prev, 0);

    // Four bad words drop lock with a single-cycle pulse.
    ll_prev = ll_count;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i < 4) ? BAD : PAT, 1'b0, 1'b0, 1'b0);
      if (i == 5) checkOutput("loss4_still_locked", locked, 1);
      if (i == 6) begin
        checkOutput("loss4_pulse", lock_lost, 1);
        checkOutput("loss4_unlocked", locked, 0);
        checkOutput("loss4_shift", shift, 0);
      end
      if (i == 7) checkOutput("loss4_pulse_end", lock_lost, 0);
    end
    checkOutput("loss4_pulse_count", ll_count - ll_prev, 1);

    for (int i = 0; i < 20; i++) applyStimulus(PAT, 1'b0, 1'b0, 1'b0);
    checkOutput("relock", locked, 1);

    // Asynchronous reset while locked.
    resetn = 1'b0;
    #1;
    checkOutput("midrst_dout", dout, 0);
    checkOutput("midrst_locked", locked, 0);
    checkOutput("midrst_valid", dout_valid, 0);
    checkOutput("midrst_lock_lost", lock_lost, 0);
    doReset();

    // Stream rotated by three bits needs three slips.
    for (int i = 0; i < 10; i++) applyStimulus(OFF, 1'b0, 1'b0, 1'b0);
    checkOutput("off_unlocked", locked, 0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(OFF, 1'b1, 1'b1, 1'b0);
      checkOutput("off_shift_step", shift, k);
      repeat (63) applyStimulus(OFF, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("off_locked", locked, 1);
    checkOutput("off_shift", shift, 3);
    checkOutput("off_dout", dout, PAT);

    // Slip from LOCKED, walk to 9, wrap, then a slip inside SETTLE is dropped.
    applyStimulus(OFF, 1'b1, 1'b1, 1'b0);
    checkOutput("slip_locked_pulse", lock_lost, 1);
    checkOutput("slip_locked_unlock", locked, 0);
    checkOutput("slip_locked_shift", shift, 4);
    repeat (7) applyStimulus(OFF, 1'b0, 1'b0, 1'b0);
    for (int k = 5; k <= 9; k++) begin
      applyStimulus(OFF, 1'b1, 1'b1, 1'b0);
      checkOutput("walk_shift", shift, k);
      repeat (7) applyStimulus(OFF, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(OFF, 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_shift", shift, 0);
    applyStimulus(OFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(OFF, 1'b1, 1'b0, 1'b0);
    checkOutput("settle_ignore", shift, 0);
    repeat (10) applyStimulus(OFF, 1'b0, 1'b0, 1'b0);
    checkOutput("settle_ignore_late", shift, 0);

    // Twenty slips without lock raise a sticky error.
    doReset();
    for (int k = 1; k <= 20; k++) begin
      rw = 10'($urandom);
      applyStimulus(rw, 1'b1, 1'b1, 1'b0);
      if (k == 19) checkOutput("err_before", align_err, 0);
      if (k == 20) checkOutput("err_set", align_err, 1);
      for (int i = 0; i < 63; i++) begin
        rw = 10'($urandom);
        applyStimulus(rw, 1'b0, 1'b0, 1'b0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      rw = 10'($urandom);
      applyStimulus(rw, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
        rw = 10'($urandom);
        applyStimulus(rw, 1'b0, 1'b0, 1'b0);
      end
    end
    checkOutput("err_persist", align_err, 1);
    checkOutput("err_shift", shift, 2);
    rw = 10'($urandom);
    applyStimulus(rw, 1'b0, 1'b0, 1'b1);
    checkOutput("err_cleared", align_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
